eth_tx_arbiter: RTL and testbench

Packet-granular arbiter that shares the Ethernet MAC transmit AXI-Stream input (`s_tx_axis_*` on `ethernet_mac`) between NUM_SRC upstream frame sources, for example the UDP/IP TX path and an ARP responder. It grants one source at a time and holds the grant for a whole frame, from first beat through the `tlast` beat. It releases the grant only after the `tlast` handshake, so frames are never interleaved on the MAC byte stream. It sits in the 125 MHz MAC TX clock domain, directly in front of the MAC.

---
 rtl/eth_tx_arbiter.sv | 164 ++++++++++++++++
 tb/tb_eth_tx_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_arbiter.sv
// rtl/eth_tx_arbiter.sv - packet-granular arbiter sharing the MAC TX byte stream between NUM_SRC sources
//
// Ports:
//   clk_125, reset            MAC TX clock; synchronous active-high reset
//   s_axis_tdata/tvalid/tlast per-source frame streams (source i at [i*DATA_WIDTH +: DATA_WIDTH])
//   s_axis_trdy               per-source ready, at most one bit high
//   m_tx_axis_tdata/tvalid/tlast/trdy  stream towards the MAC
//   grant_id                  currently or most recently granted source
//   busy                      high while a grant is held
//   frame_cnt                 frames completed through the arbiter (wraps)
//
// Build option: ETH_TX_ARB_STRICT_PRIO_EN selects fixed priority (lowest index wins)
// instead of round-robin.

module eth_tx_arbiter #(
    parameter int NUM_SRC    = 2,
    parameter int DATA_WIDTH = 8,
    parameter int SEL_W      = $clog2(NUM_SRC)
) (
    input  logic                          clk_125,
    input  logic                          reset,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]            s_axis_tvalid,
    input  logic [NUM_SRC-1:0]            s_axis_tlast,
    output logic [NUM_SRC-1:0]            s_axis_trdy,
    output logic [DATA_WIDTH-1:0]         m_tx_axis_tdata,
    output logic                          m_tx_axis_tvalid,
    output logic                          m_tx_axis_tlast,
    input  logic                          m_tx_axis_trdy,
    output logic [SEL_W-1:0]              grant_id,
    output logic                          busy,
    output logic [15:0]                   frame_cnt
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [SEL_W-1:0]        grant_q, grant_d;
    logic [15:0]             frame_cnt_q, frame_cnt_d;
    logic [SEL_W-1:0]        winner;
    logic                    any_req;

    // Selected source, valid only while a grant is held
    logic [DATA_WIDTH-1:0]   sel_tdata;
    logic                    sel_tvalid;
    logic                    sel_tlast;

    assign any_req    = |s_axis_tvalid;
    assign sel_tdata  = s_axis_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
    assign sel_tvalid = s_axis_tvalid[grant_q];
    assign sel_tlast  = s_axis_tlast[grant_q];

`ifdef ETH_TX_ARB_STRICT_PRIO_EN

    // Fixed priority: scan from the highest index down so the lowest
    // requesting index is the last one written and therefore wins.
    always_comb begin
        winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (s_axis_tvalid[i]) begin
                winner = SEL_W'(i);
            end
        end
    end

`else

    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0] cand;

    // Modulo-NUM_SRC increment that also works when NUM_SRC is not a power of two
    function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_SRC) begin
            sum = sum - NUM_SRC;
        end
        return SEL_W'(sum);
    endfunction

    // Round-robin: candidates are visited from the furthest offset back to
    // rr_ptr itself, so the requester closest to rr_ptr is written last and wins.
    always_comb begin
        winner = '0;
        cand   = '0;
        for (int off = NUM_SRC - 1; off >= 0; off--) begin
            cand = wrap_add(rr_ptr_q, off);
            if (s_axis_tvalid[cand]) begin
                winner = cand;
            end
        end
    end

`endif

    // Next state and outputs. Outputs default to zero so nothing from the
    // source mux reaches the MAC while idle.
    always_comb begin
        state_d          = state_q;
        grant_d          = grant_q;
        frame_cnt_d      = frame_cnt_q;
`ifndef ETH_TX_ARB_STRICT_PRIO_EN
        rr_ptr_d         = rr_ptr_q;
`endif
        s_axis_trdy      = '0;
        m_tx_axis_tdata  = '0;
        m_tx_axis_tvalid = 1'b0;
        m_tx_axis_tlast  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_ACTIVE;
                    grant_d = winner;
                end
            end

            ST_ACTIVE: begin
                m_tx_axis_tdata      = sel_tdata;
                m_tx_axis_tvalid     = sel_tvalid;
                m_tx_axis_tlast      = sel_tlast;
                s_axis_trdy[grant_q] = m_tx_axis_trdy;
                // Grant is released only on the tlast handshake; tvalid gaps hold it.
                if (sel_tvalid && sel_tlast && m_tx_axis_trdy) begin
                    state_d     = ST_IDLE;
                    frame_cnt_d = frame_cnt_q + 16'd1;
`ifndef ETH_TX_ARB_STRICT_PRIO_EN
                    rr_ptr_d    = wrap_add(grant_q, 1);
`endif
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_125) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            frame_cnt_q <= '0;
`ifndef ETH_TX_ARB_STRICT_PRIO_EN
            rr_ptr_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            frame_cnt_q <= frame_cnt_d;
`ifndef ETH_TX_ARB_STRICT_PRIO_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    assign grant_id  = grant_q;
    assign busy      = (state_q == ST_ACTIVE);
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb/tb_eth_tx_arbiter.sv - self-checking bench for eth_tx_arbiter
module tb_eth_tx_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk_125 = 1'b0;
    logic           reset   = 1'b1;
    logic [N*W-1:0] s_axis_tdata  = '0;
    logic [N-1:0]   s_axis_tvalid = '0;
    logic [N-1:0]   s_axis_tlast  = '0;
    logic [N-1:0]   s_axis_trdy;
    logic [W-1:0]   m_tx_axis_tdata;
    logic           m_tx_axis_tvalid;
    logic           m_tx_axis_tlast;
    logic           m_tx_axis_trdy = 1'b1;
    logic [1:0]     grant_id;
    logic           busy;
    logic [15:0]    frame_cnt;

    int n_pass  = 0;
    int n_total = 0;

    eth_tx_arbiter #(.NUM_SRC(N), .DATA_WIDTH(W)) dut (
        .clk_125          (clk_125),
        .reset            (reset),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tlast     (s_axis_tlast),
        .s_axis_trdy      (s_axis_trdy),
        .m_tx_axis_tdata  (m_tx_axis_tdata),
        .m_tx_axis_tvalid (m_tx_axis_tvalid),
        .m_tx_axis_tlast  (m_tx_axis_tlast),
        .m_tx_axis_trdy   (m_tx_axis_trdy),
        .grant_id         (grant_id),
        .busy             (busy),
        .frame_cnt        (frame_cnt)
    );

    always #4 clk_125 = ~clk_125;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d required %0d", name, act, exp);
    endtask

    // ---------------- reference model: frame-level arbitration rules ----------------
    bit m_ok = 0;
    bit mb   = 0;
    int mg   = 0;
    int mp   = 0;
    int mc   = 0;

    function automatic int pick(input logic [N-1:0] v, input int ptr);
`ifdef ETH_TX_ARB_STRICT_PRIO_EN
        for (int k = 0; k < N; k++) if (v[k]) return k;
`else
        for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
`endif
        return 0;
    endfunction

    always @(posedge clk_125) begin
        if (reset) begin
            mb = 0; mg = 0; mp = 0; mc = 0; m_ok = 1;
        end else if (!mb) begin
            if (s_axis_tvalid != '0) begin
                mg = pick(s_axis_tvalid, mp);
                mb = 1;
            end
        end else if (s_axis_tvalid[mg] && s_axis_tlast[mg] && m_tx_axis_trdy) begin
            mb = 0;
            mp = (mg + 1) % N;
            mc = (mc + 1) % 65536;
        end
    end

    always @(negedge clk_125) begin
        logic [N-1:0] etrdy;
        logic [W-1:0] ed;
        logic         ev;
        logic         el;
        if (m_ok) begin
            etrdy = '0; ed = '0; ev = 1'b0; el = 1'b0;
            if (mb) begin
                ed        = s_axis_tdata[mg*W +: W];
                ev        = s_axis_tvalid[mg];
                el        = s_axis_tlast[mg];
                etrdy[mg] = m_tx_axis_trdy;
            end
            n_total++;
            if ({busy, grant_id, frame_cnt, s_axis_trdy, m_tx_axis_tvalid, m_tx_axis_tlast, m_tx_axis_tdata}
                === {mb, 2'(mg), 16'(mc), etrdy, ev, el, ed} && $onehot0(s_axis_trdy))
                n_pass++;
            else
                $display("FAIL cycle t=%0t busy/gnt/cnt/trdy/v/l/d got %b/%0d/%h/%b/%b/%b/%h required %b/%0d/%h/%b/%b/%b/%h",
                         $time, busy, grant_id, frame_cnt, s_axis_trdy, m_tx_axis_tvalid, m_tx_axis_tlast,
                         m_tx_axis_tdata, mb, mg, 16'(mc), etrdy, ev, el, ed);
        end
    end

    // ---------------- output monitor ----------------
    int out_q[$];
    int gnt_order[$];
    int len_q[$];
    int cur_len = 0;
    int exp_src[$];
    int exp_len[$];

    always @(negedge clk_125) begin
        if (!reset && m_tx_axis_tvalid && m_tx_axis_trdy) begin
            out_q.push_back(int'(m_tx_axis_tdata));
            cur_len++;
            if (m_tx_axis_tlast) begin
                gnt_order.push_back(int'(grant_id));
                len_q.push_back(cur_len);
                cur_len = 0;
            end
        end
    end

    // ---------------- frame sources ----------------
    int         flen[N];
    int         fpos[N];
    int         nfr[N];
    int         gap_pos[N];
    int         gap_left[N];
    bit         toggle_rdy = 0;
    bit [N-1:0] hs;

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (nfr[i] > 0 && gap_left[i] == 0) begin
                s_axis_tvalid[i]      = 1'b1;
                s_axis_tlast[i]       = (fpos[i] == flen[i] - 1);
                s_axis_tdata[i*W +: W] = 8'(i * 64 + fpos[i]);
            end else begin
                s_axis_tvalid[i]      = 1'b0;
                s_axis_tlast[i]       = 1'b0;
                s_axis_tdata[i*W +: W] = 8'hA5;
            end
        end
    endtask

    task automatic step();
        @(negedge clk_125);
        hs = s_axis_tvalid & s_axis_trdy;
        @(posedge clk_125);
        #1;
        for (int i = 0; i < N; i++) begin
            if (gap_left[i] > 0) gap_left[i]--;
            if (hs[i]) begin
                fpos[i]++;
                if (fpos[i] == flen[i]) begin
                    fpos[i] = 0;
                    nfr[i]--;
                end else if (fpos[i] == gap_pos[i]) begin
                    gap_left[i] = 3;
                    gap_pos[i]  = -1;
                end
            end
        end
        if (toggle_rdy) m_tx_axis_trdy = ~m_tx_axis_trdy;
        drive();
    endtask

    function automatic bit pending();
        for (int i = 0; i < N; i++) if (nfr[i] > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic clear_src();
        for (int i = 0; i < N; i++) begin
            flen[i] = 1; fpos[i] = 0; nfr[i] = 0; gap_pos[i] = -1; gap_left[i] = 0;
        end
    endtask

    task automatic clear_mon();
        out_q.delete(); gnt_order.delete(); len_q.delete();
        exp_src.delete(); exp_len.delete();
        cur_len = 0;
    endtask

    task automatic do_reset();
        @(posedge clk_125); #1;
        reset = 1'b1;
        clear_src();
        drive();
        @(posedge clk_125); #1;
        reset = 1'b0;
        clear_mon();
    endtask

    task automatic run(input string name, input int budget);
        int b;
        b = 0;
        while (pending() && b < budget) begin
            step();
            b++;
        end
        chk({name, "_timeout"}, longint'(pending()), 0);
        repeat (3) step();
    endtask

    task automatic check_stream(input string name);
        int errs;
        int k;
        errs = 0;
        k    = 0;
        chk({name, "_frames"}, gnt_order.size(), exp_src.size());
        for (int f = 0; f < exp_src.size() && f < gnt_order.size(); f++) begin
            chk($sformatf("%s_gnt%0d", name, f), gnt_order[f], exp_src[f]);
            chk($sformatf("%s_len%0d", name, f), len_q[f], exp_len[f]);
        end
        for (int f = 0; f < exp_src.size(); f++) begin
            for (int j = 0; j < exp_len[f]; j++) begin
                if (k >= out_q.size() || out_q[k] != (exp_src[f] * 64 + j) % 256) errs++;
                k++;
            end
        end
        chk({name, "_bad_bytes"}, errs, 0);
        chk({name, "_nbytes"}, out_q.size(), k);
    endtask

    initial begin
        clear_src();
        clear_mon();
        drive();

        // Reset state
        @(posedge clk_125);
        @(negedge clk_125);
        chk("rst_busy", busy, 0);
        chk("rst_trdy", s_axis_trdy, 0);
        chk("rst_tvalid", m_tx_axis_tvalid, 0);
        chk("rst_tlast", m_tx_axis_tlast, 0);
        chk("rst_tdata", m_tx_axis_tdata, 0);
        chk("rst_cnt", frame_cnt, 0);
        chk("rst_gnt", grant_id, 0);
        @(posedge clk_125); #1;
        reset = 1'b0;

        // Single source, 64-byte frame
        do_reset();
        nfr[1] = 1; flen[1] = 64;
        drive();
        run("t1", 200);
        exp_src = '{1}; exp_len = '{64};
        check_stream("t1");
        chk("t1_cnt", frame_cnt, 1);
        chk("t1_gnt", grant_id, 1);

        // Contention, two continuous requesters
        do_reset();
        nfr[0] = 2; flen[0] = 10;
        nfr[1] = 2; flen[1] = 10;
        drive();
        run("t2", 200);
`ifdef ETH_TX_ARB_STRICT_PRIO_EN
        exp_src = '{0, 0, 1, 1};
`else
        exp_src = '{0, 1, 0, 1};
`endif
        exp_len = '{10, 10, 10, 10};
        check_stream("t2");
        chk("t2_cnt", frame_cnt, 4);

        // Backpressure toggling and a 3-cycle tvalid gap mid-frame
        do_reset();
        toggle_rdy = 1;
        nfr[0] = 1; flen[0] = 30; gap_pos[0] = 10;
        nfr[1] = 1; flen[1] = 20;
        drive();
        run("t3", 400);
        toggle_rdy = 0;
        m_tx_axis_trdy = 1'b1;
        exp_src = '{0, 1}; exp_len = '{30, 20};
        check_stream("t3");
        chk("t3_cnt", frame_cnt, 2);

        // Reset in the middle of a frame
        do_reset();
        nfr[1] = 1; flen[1] = 1;
        drive();
        run("t4a", 50);
        chk("t4_pre_cnt", frame_cnt, 1);
        nfr[3] = 1; flen[3] = 50;
        drive();
        begin
            int b;
            b = 0;
            while (fpos[3] != 20 && b < 200) begin
                step();
                b++;
            end
        end
        chk("t4_reach20", fpos[3], 20);
        reset = 1'b1;
        step();
        reset = 1'b0;
        fpos[3] = 0;
        clear_mon();
        drive();
        @(negedge clk_125);
        chk("t4_busy", busy, 0);
        chk("t4_trdy", s_axis_trdy, 0);
        chk("t4_cnt0", frame_cnt, 0);
        chk("t4_gnt0", grant_id, 0);
        run("t4b", 200);
        exp_src = '{3}; exp_len = '{50};
        check_stream("t4");
        chk("t4_cnt", frame_cnt, 1);

        // Counter wrap
        do_reset();
        force dut.frame_cnt_q = 16'hFFFF;
        mc = 65535;
        step();
        release dut.frame_cnt_q;
        @(negedge clk_125);
        chk("t5_preload", frame_cnt, 16'hFFFF);
        @(posedge clk_125); #1;
        nfr[2] = 1; flen[2] = 1;
        drive();
        run("t5", 50);
        exp_src = '{2}; exp_len = '{1};
        check_stream("t5");
        chk("t5_wrap", frame_cnt, 0);

        // Random traffic; the per-cycle model compare covers one-hot ready and no interleaving
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk_125); #1;
            s_axis_tvalid  = 4'($urandom);
            s_axis_tlast   = 4'($urandom);
            s_axis_tdata   = 32'($urandom);
            m_tx_axis_trdy = 1'($urandom);
        end
        @(posedge clk_125); #1;
        s_axis_tvalid  = '0;
        s_axis_tlast   = '0;
        m_tx_axis_trdy = 1'b1;
        repeat (2) @(posedge clk_125);
        @(negedge clk_125);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
